// File: rtl/sum_feeder_pkg.sv
// Shared types and defaults for the sum_feeder stimulus/check stage.
package sum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO,
    ST_FEED,
    ST_TERM,
    ST_WAIT,
    ST_REPORT
  } feed_state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_TIMEOUT = 16;

  // Zero ends a stream on the summer's input, so it can never be a data value.
  localparam logic [DEF_WIDTH-1:0] TERM_VAL = '0;

endpackage

// File: rtl/sum_feeder_if.sv
// Host + summer signal bundle; master is the host/summer side, slave is sum_feeder.
interface sum_feeder_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             clear;
  logic             start;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             go_l;
  logic [WIDTH-1:0] inA;
  logic             busy;
  logic [WIDTH-1:0] tb_sum;
  logic             match;
  logic             mismatch;
  logic             timeout;
  logic [CW-1:0]    count;

  modport master (
    output load_en, load_data, clear, start, done, result,
    input  go_l, inA, busy, tb_sum, match, mismatch, timeout, count
  );

  modport slave (
    input  load_en, load_data, clear, start, done, result,
    output go_l, inA, busy, tb_sum, match, mismatch, timeout, count
  );
endinterface

// File: rtl/sum_feeder_buffer.sv
// Append-only value buffer with count/full and a combinational read port.
module feed_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic [$clog2(DEPTH+1)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign wr_ok   = wr_en_i && !full_o && !clear_i;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i)    count_d = '0;
    else if (wr_ok) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // Contents are left unreset; only count defines what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[count_q[AW-1:0]] <= wr_data_i;
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_addr_i < CW'(DEPTH)) rd_data_o = mem_q[rd_addr_i[AW-1:0]];
  end
endmodule

// File: rtl/sum_feeder.sv
// Streams buffered values to the summer, builds the expected sum, checks the reply.
//   state  | meaning
//   IDLE   | accept load/clear/start from host
//   GO     | go_l low with first value
//   FEED   | remaining values, one per cycle
//   TERM   | zero terminator on inA
//   WAIT   | wait for done or timeout
//   REPORT | one-cycle match/mismatch/timeout pulse
import sum_pkg::*;

module sum_feeder #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic         clock_i,
  input logic         reset_i,
  sum_feeder_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] TV = WIDTH'(TERM_VAL);

  feed_state_t      state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic             go_l_q, go_l_d;
  logic [WIDTH-1:0] in_a_q, in_a_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             busy_q, busy_d;
  logic             match_q, match_d;
  logic             mism_q, mism_d;
  logic             tout_q, tout_d;

  logic [CW-1:0]    rd_addr, cnt;
  logic [WIDTH-1:0] rd_data;
  logic             buf_wr, buf_clr, full;

  feed_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .clear_i   (buf_clr),
    .wr_en_i   (buf_wr),
    .wr_data_i (bus.load_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .count_o   (cnt),
    .full_o    (full)
  );

  // Outputs are computed for the state being entered so they are registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    go_l_d  = 1'b1;
    in_a_d  = TV;
    sum_d   = sum_q;
    match_d = 1'b0;
    mism_d  = 1'b0;
    tout_d  = 1'b0;
    buf_wr  = 1'b0;
    buf_clr = 1'b0;
    rd_addr = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_GO;
          go_l_d  = 1'b0;
          in_a_d  = (cnt == '0) ? TV : rd_data;
          sum_d   = '0;
          idx_d   = CW'(1);
        end else if (bus.clear) begin
          buf_clr = 1'b1;
        end else if (bus.load_en && (bus.load_data != TV) && !full) begin
          buf_wr = 1'b1;
        end
      end
      ST_GO: begin
        sum_d   = sum_q + in_a_q;
        rd_addr = CW'(1);
        if (cnt <= CW'(1)) begin
          state_d = ST_TERM;
        end else begin
          state_d = ST_FEED;
          in_a_d  = rd_data;
          idx_d   = CW'(1);
        end
      end
      ST_FEED: begin
        sum_d   = sum_q + in_a_q;
        rd_addr = idx_q + CW'(1);
        if (idx_q == cnt - CW'(1)) begin
          state_d = ST_TERM;
        end else begin
          idx_d  = idx_q + CW'(1);
          in_a_d = rd_data;
        end
      end
      ST_TERM: begin
        state_d = ST_WAIT;
        wcnt_d  = '0;
      end
      ST_WAIT: begin
        if (bus.done) begin
          state_d = ST_REPORT;
          match_d = (bus.result == sum_q);
          mism_d  = (bus.result != sum_q);
        end else if (wcnt_q == TW'(TIMEOUT)) begin
          state_d = ST_REPORT;
          tout_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      go_l_q  <= 1'b1;
      in_a_q  <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      match_q <= 1'b0;
      mism_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      go_l_q  <= go_l_d;
      in_a_q  <= in_a_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      match_q <= match_d;
      mism_q  <= mism_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.go_l     = go_l_q;
  assign bus.inA      = in_a_q;
  assign bus.busy     = busy_q;
  assign bus.tb_sum   = sum_q;
  assign bus.match    = match_q;
  assign bus.mismatch = mism_q;
  assign bus.timeout  = tout_q;
  assign bus.count    = cnt;
endmodule

// File: tb/tb_sum_feeder.sv
// Directed + randomized bench for sum_feeder with a queue-based reference model.
module tb_sum_feeder;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int TO = 16;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [W-1:0] model_q[$];

  sum_feeder_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sum_feeder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] model_sum();
    logic [W-1:0] s = '0;
    foreach (model_q[i]) s = s + model_q[i];
    return s;
  endfunction

  task automatic load(input logic [W-1:0] v);
    bus.load_en   = 1'b1;
    bus.load_data = v;
    step();
    bus.load_en   = 1'b0;
    if (v != 0 && model_q.size() < D) model_q.push_back(v);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    model_q.delete();
  endtask

  // One full run: stream check, tb_sum check, then reply (or stay silent) and check the report.
  task automatic run(input bit give_done, input logic [W-1:0] resp, input int delay,
                     input bit poke_start);
    logic [W-1:0] vals[$];
    logic [W-1:0] es;
    int n;
    vals = model_q;
    if (vals.size() == 0) vals.push_back('0);
    n  = vals.size();
    es = model_sum();

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("go_low", {31'd0, bus.go_l}, 32'd0);
    chk("inA_first", {24'd0, bus.inA}, {24'd0, vals[0]});
    chk("busy_run", {31'd0, bus.busy}, 32'd1);
    for (int k = 1; k < n; k++) begin
      if (poke_start) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("go_high", {31'd0, bus.go_l}, 32'd1);
      chk("inA_val", {24'd0, bus.inA}, {24'd0, vals[k]});
    end
    step();
    chk("inA_term", {24'd0, bus.inA}, 32'd0);
    chk("go_term", {31'd0, bus.go_l}, 32'd1);
    step();
    chk("tb_sum", {24'd0, bus.tb_sum}, {24'd0, es});

    if (give_done) begin
      repeat (delay) step();
      bus.done   = 1'b1;
      bus.result = resp;
      if (poke_start) bus.start = 1'b1;
      step();
      bus.done  = 1'b0;
      bus.start = 1'b0;
      chk("match", {31'd0, bus.match}, {31'd0, resp == es});
      chk("mismatch", {31'd0, bus.mismatch}, {31'd0, resp != es});
      chk("no_timeout", {31'd0, bus.timeout}, 32'd0);
      chk("busy_report", {31'd0, bus.busy}, 32'd1);
      step();
      chk("busy_idle", {31'd0, bus.busy}, 32'd0);
      chk("pulse_gone", {29'd0, bus.match, bus.mismatch, bus.timeout}, 32'd0);
    end else begin
      repeat (TO) step();
      chk("timeout_early", {31'd0, bus.timeout}, 32'd0);
      step();
      chk("timeout", {31'd0, bus.timeout}, 32'd1);
      chk("timeout_only", {30'd0, bus.match, bus.mismatch}, 32'd0);
      step();
      chk("busy_after_to", {31'd0, bus.busy}, 32'd0);
      chk("timeout_gone", {31'd0, bus.timeout}, 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] es;
    logic [W-1:0] resp;
    int nv;

    rst = 1'b1;
    bus.load_en = 0; bus.load_data = 0; bus.clear = 0;
    bus.start = 0; bus.done = 0; bus.result = 0;
    step();
    step();
    chk("rst_go_l", {31'd0, bus.go_l}, 32'd1);
    chk("rst_inA", {24'd0, bus.inA}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_tb_sum", {24'd0, bus.tb_sum}, 32'd0);
    chk("rst_pulses", {29'd0, bus.match, bus.mismatch, bus.timeout}, 32'd0);
    chk("rst_count", {28'd0, bus.count}, 32'd0);
    rst = 1'b0;
    step();

    // 4,4,4 -> 12, correct reply
    load(8'd4); load(8'd4); load(8'd4);
    chk("count3", {28'd0, bus.count}, 32'd3);
    run(1'b1, 8'd12, 2, 1'b0);

    // Replay: buffer persists across a run
    chk("count_persist", {28'd0, bus.count}, 32'd3);
    run(1'b1, 8'd12, 0, 1'b1);

    // 200+100 wraps to 44
    do_clear();
    load(8'd200); load(8'd100);
    run(1'b1, 8'd44, 1, 1'b0);

    // 3,3,3 -> 9 but summer says 10
    do_clear();
    load(8'd3); load(8'd3); load(8'd3);
    run(1'b1, 8'd10, 3, 1'b0);

    // Single value, no reply
    do_clear();
    load(8'd5);
    run(1'b0, 8'd0, 0, 1'b0);

    // Stray done while idle
    bus.done = 1'b1; bus.result = 8'd5;
    step();
    bus.done = 1'b0;
    chk("stray_done_pulse", {29'd0, bus.match, bus.mismatch, bus.timeout}, 32'd0);
    chk("stray_done_busy", {31'd0, bus.busy}, 32'd0);

    // Buffer limits
    do_clear();
    load(8'd0);
    chk("zero_ignored", {28'd0, bus.count}, 32'd0);
    for (int i = 1; i <= 9; i++) load(W'(i));
    chk("full_count", {28'd0, bus.count}, 32'd8);
    bus.clear = 1'b1; bus.load_en = 1'b1; bus.load_data = 8'd7;
    step();
    bus.clear = 1'b0; bus.load_en = 1'b0;
    model_q.delete();
    chk("clear_over_load", {28'd0, bus.count}, 32'd0);
    run(1'b1, 8'd0, 1, 1'b0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      do_clear();
      nv = $urandom_range(1, 11);
      for (int i = 0; i < nv; i++)
        load(($urandom_range(0, 4) == 0) ? W'(0) : W'($urandom_range(1, 255)));
      chk("rand_count", {28'd0, bus.count}, model_q.size());
      es   = model_sum();
      resp = ($urandom_range(0, 1) == 1) ? es : es + W'($urandom_range(1, 255));
      run(1'b1, resp, $urandom_range(0, 8), $urandom_range(0, 1) == 1);
    end

    // Reset during FEED
    do_clear();
    for (int i = 1; i <= 6; i++) load(W'(10 * i));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_go_l", {31'd0, bus.go_l}, 32'd1);
    chk("midrst_inA", {24'd0, bus.inA}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_count", {28'd0, bus.count}, 32'd0);
    chk("midrst_tb_sum", {24'd0, bus.tb_sum}, 32'd0);
    rst = 1'b0;
    model_q.delete();
    step();
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
